// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: register file, operand select, multi-op ALU, registered writeback with forwarding.
// Define ALU_MUL_EN to build the iterative radix-2 multiplier (ALUctrl=1010) and its IDLE/MUL FSM.
module alu_exec_pipe #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int A0_INDEX      = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [3:0]               ALUctrl,
  input  logic [DATA_WIDTH-1:0]    immOp,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    ALUout,
  output logic                     EQ,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int SHW  = $clog2(DATA_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(A0_INDEX);

  logic [DATA_WIDTH-1:0]    rf_q [NREG];
  logic                     wb_we_q;
  logic [ADDRESS_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;
  logic [DATA_WIDTH-1:0]    alu_q;
  logic                     eq_q;
  logic                     out_valid_q;

  logic                     accept;
  logic                     issue_single;
  logic [DATA_WIDTH-1:0]    op1, op2, rs2_val, alu_res;
  logic                     res_load, res_eq, res_we;
  logic [DATA_WIDTH-1:0]    res_data;
  logic [ADDRESS_WIDTH-1:0] res_rd;

  function automatic logic [DATA_WIDTH-1:0] alu_op(input logic [3:0] ctrl,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (ctrl)
      4'b0000: alu_op = a + b;
      4'b0001: alu_op = a - b;
      4'b0010: alu_op = a & b;
      4'b0011: alu_op = a | b;
      4'b0100: alu_op = a ^ b;
      4'b0101: alu_op = a << sh;
      4'b0110: alu_op = a >> sh;
      4'b0111: alu_op = $unsigned($signed(a) >>> sh);
      4'b1000: alu_op = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1001: alu_op = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: alu_op = '0;
    endcase
  endfunction

  // Operand read: x0 reads zero, a pending WB write overrides the stale register-file value.
  function automatic logic [DATA_WIDTH-1:0] read_fwd(input logic [ADDRESS_WIDTH-1:0] idx);
    if (idx == '0)                            read_fwd = '0;
    else if (wb_we_q && (wb_rd_q == idx))     read_fwd = wb_data_q;
    else                                      read_fwd = rf_q[idx];
  endfunction

  assign op1     = read_fwd(rs1);
  assign rs2_val = read_fwd(rs2);
  assign op2     = ALUsrc ? immOp : rs2_val;
  assign alu_res = alu_op(ALUctrl, op1, op2);
  assign accept  = in_valid && in_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(DATA_WIDTH - 1);

  state_e                   state_q, state_d;
  logic                     is_mul, mul_step, mul_done;
  logic [DATA_WIDTH-1:0]    mcand_q, mplier_q, acc_q, mul_sum;
  logic [SHW-1:0]           cnt_q;
  logic [ADDRESS_WIDTH-1:0] mul_rd_q;
  logic                     mul_we_q, mul_eq_q;

  assign is_mul       = (ALUctrl == 4'b1010);
  assign issue_single = accept && !is_mul;
  assign mul_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    busy     = (state_q == S_MUL);
    mul_step = (state_q == S_MUL);
    mul_done = (state_q == S_MUL) && (cnt_q == CNT_LAST);
  end

  // One multiplier bit per cycle; the last step's sum goes straight to the result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_rd_q <= '0;
      mul_we_q <= 1'b0;
      mul_eq_q <= 1'b0;
    end else if (accept && is_mul) begin
      mcand_q  <= op1;
      mplier_q <= op2;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_rd_q <= rd;
      mul_we_q <= RegWrite;
      mul_eq_q <= (op1 == op2);
    end else if (mul_step) begin
      acc_q    <= mul_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign in_ready     = 1'b1;
  assign busy         = 1'b0;
  assign issue_single = accept;
`endif

  always_comb begin
    res_load = issue_single;
    res_data = alu_res;
    res_eq   = (op1 == op2);
    res_rd   = rd;
    res_we   = RegWrite;
`ifdef ALU_MUL_EN
    if (mul_done) begin
      res_load = 1'b1;
      res_data = mul_sum;
      res_eq   = mul_eq_q;
      res_rd   = mul_rd_q;
      res_we   = mul_we_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q       <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      out_valid_q <= res_load;
      wb_we_q     <= res_load && res_we;
      if (res_load) begin
        alu_q     <= res_data;
        eq_q      <= res_eq;
        wb_rd_q   <= res_rd;
        wb_data_q <= res_data;
      end
    end
  end

  // Register file commits one edge after the WB stage loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_we_q && (wb_rd_q != '0)) begin
      rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  assign ALUout    = alu_q;
  assign EQ        = eq_q;
  assign out_valid = out_valid_q;
  assign a0        = rf_q[A0_IDX];

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Self-checking bench for alu_exec_pipe: architectural reference model plus directed literal checks.
module tb_alu_exec_pipe;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          RegWrite = 1'b0;
  logic          ALUsrc = 1'b0;
  logic [3:0]    ALUctrl = 4'd0;
  logic [DW-1:0] immOp = '0;
  logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic          out_valid;
  logic [DW-1:0] ALUout;
  logic          EQ;
  logic          busy;
  logic [DW-1:0] a0;

  alu_exec_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .immOp(immOp),
    .rs1(rs1), .rs2(rs2), .rd(rd), .out_valid(out_valid), .ALUout(ALUout),
    .EQ(EQ), .busy(busy), .a0(a0)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Architectural model: each accepted instruction sees all earlier results.
  logic [DW-1:0] arch [32];
  logic [DW-1:0] exp_alu, exp_a0, mul_res;
  logic          exp_eq, exp_vld, exp_busy, mul_eqv, mul_we;
  logic [4:0]    mul_rd;
  int            mul_left;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [2*DW-1:0] ext;
    int sh;
    sh  = int'(b[4:0]);
    ext = {{DW{a[DW-1]}}, a};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return ext[DW-1:0] >> 0 == a ? DW'(ext >> sh) : '0;
      4'd8: return {31'b0, ($signed(a) < $signed(b))};
      4'd9: return {31'b0, (a < b)};
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) arch[i] = '0;
    exp_alu = '0; exp_a0 = '0; exp_eq = 1'b0; exp_vld = 1'b0; exp_busy = 1'b0;
    mul_left = 0; mul_res = '0; mul_eqv = 1'b0; mul_we = 1'b0; mul_rd = '0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] a, b, r;
    exp_vld = 1'b0;
    exp_a0  = arch[10];
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_alu = mul_res; exp_eq = mul_eqv; exp_vld = 1'b1;
        if (mul_we && mul_rd != 0) arch[mul_rd] = mul_res;
      end
    end else if (in_valid) begin
      a = (rs1 == 0) ? '0 : arch[rs1];
      b = ALUsrc ? immOp : ((rs2 == 0) ? '0 : arch[rs2]);
`ifdef ALU_MUL_EN
      if (ALUctrl == 4'd10) begin
        mul_left = DW; mul_res = a * b; mul_eqv = (a == b); mul_we = RegWrite; mul_rd = rd;
      end else
`endif
      begin
        r = ref_alu(ALUctrl, a, b);
        exp_alu = r; exp_eq = (a == b); exp_vld = 1'b1;
        if (RegWrite && rd != 0) arch[rd] = r;
      end
    end
    exp_busy = (mul_left > 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_vld});
    chk("ALUout", ALUout, exp_alu);
    chk("EQ", {31'b0, EQ}, {31'b0, exp_eq});
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("in_ready", {31'b0, in_ready}, {31'b0, !exp_busy});
    chk("a0", a0, exp_a0);
  end

  task automatic issue(input logic [3:0] op, input logic src, input logic [DW-1:0] imm,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic we);
    in_valid = 1'b1; ALUctrl = op; ALUsrc = src; immOp = imm;
    rs1 = r1; rs2 = r2; rd = d; RegWrite = we;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    int got;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    chk("rst_ALUout", ALUout, 32'h0);
    chk("rst_ready", {31'b0, in_ready}, 32'h1);

    // Directed: writes, forwarding, readback
    issue(4'd0, 1'b1, 32'd5, 5'd0, 5'd0, 5'd1, 1'b1);
    chk("t1_add", ALUout, 32'd5);
    chk("t1_vld", {31'b0, out_valid}, 32'h1);
    chk("t1_eq", {31'b0, EQ}, 32'h0);
    issue(4'd0, 1'b0, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1);
    chk("t2_fwd", ALUout, 32'd10);
    issue(4'd1, 1'b0, 32'd0, 5'd2, 5'd2, 5'd3, 1'b1);
    chk("t2_sub", ALUout, 32'd0);
    chk("t2_eq", {31'b0, EQ}, 32'h1);
    issue(4'd0, 1'b1, 32'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    chk("t1_readx1", ALUout, 32'd5);

    // Comparisons and shifts
    issue(4'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd3, 1'b1);
    issue(4'd0, 1'b1, 32'd1, 5'd0, 5'd0, 5'd4, 1'b1);
    issue(4'd0, 1'b1, 32'h8000_0000, 5'd0, 5'd0, 5'd5, 1'b1);
    issue(4'd8, 1'b0, 32'd0, 5'd3, 5'd4, 5'd0, 1'b1);
    chk("t3_slt", ALUout, 32'd1);
    issue(4'd9, 1'b0, 32'd0, 5'd3, 5'd4, 5'd0, 1'b1);
    chk("t3_sltu", ALUout, 32'd0);
    issue(4'd7, 1'b1, 32'd4, 5'd5, 5'd0, 5'd0, 1'b1);
    chk("t3_sra", ALUout, 32'hF800_0000);
    issue(4'd6, 1'b1, 32'd4, 5'd5, 5'd0, 5'd0, 1'b1);
    chk("t3_srl", ALUout, 32'h0800_0000);

    // x0 and a0
    issue(4'd0, 1'b1, 32'h1234, 5'd0, 5'd0, 5'd10, 1'b1);
    idle(1);
    chk("t4_a0", a0, 32'h1234);
    issue(4'd0, 1'b1, 32'hFFFF, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("t4_x0w", ALUout, 32'hFFFF);
    chk("t4_x0v", {31'b0, out_valid}, 32'h1);
    issue(4'd0, 1'b1, 32'd0, 5'd0, 5'd0, 5'd9, 1'b0);
    chk("t4_x0r", ALUout, 32'd0);
    chk("t4_a0keep", a0, 32'h1234);

    // Multiply
    issue(4'd0, 1'b1, 32'd7, 5'd0, 5'd0, 5'd6, 1'b1);
    issue(4'd0, 1'b1, 32'd6, 5'd0, 5'd0, 5'd7, 1'b1);
    issue(4'd10, 1'b0, 32'd0, 5'd6, 5'd7, 5'd10, 1'b1);
`ifdef ALU_MUL_EN
    chk("t5_ready0", {31'b0, in_ready}, 32'h0);
    chk("t5_busy1", {31'b0, busy}, 32'h1);
    got = 0;
    for (int k = 1; k <= 100; k++) begin
      cycle();
      if (out_valid) begin got = k; break; end
    end
    chk("t5_latency", got, 32'd32);
    chk("t5_mul", ALUout, 32'd42);
    idle(1);
    chk("t5_a0", a0, 32'd42);
`else
    chk("t5_mul0", ALUout, 32'd0);
    chk("t5_ready1", {31'b0, in_ready}, 32'h1);
    idle(1);
    chk("t5_a0", a0, 32'd0);
`endif

    // Reset in the middle of a multiply
    issue(4'd10, 1'b0, 32'd0, 5'd6, 5'd7, 5'd10, 1'b1);
    idle(9);
    #2 rst_n = 1'b0;
    model_reset();
    idle(2);
    chk("t6_a0", a0, 32'd0);
    chk("t6_vld", {31'b0, out_valid}, 32'h0);
    #2 rst_n = 1'b1;
    idle(40);
    chk("t6_ready", {31'b0, in_ready}, 32'h1);
    chk("t6_busy", {31'b0, busy}, 32'h0);
    issue(4'd0, 1'b1, 32'd0, 5'd6, 5'd0, 5'd0, 1'b0);
    chk("t6_x6", ALUout, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      ALUctrl  = 4'($urandom_range(0, 15));
      ALUsrc   = 1'($urandom_range(0, 1));
      immOp    = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      rs1      = 5'($urandom_range(0, 11));
      rs2      = 5'($urandom_range(0, 11));
      rd       = 5'($urandom_range(0, 11));
      RegWrite = ($urandom_range(0, 4) != 0);
      cycle();
    end
    idle(40);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
